// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and constants for the word-copy DMA engine
//
// Purpose: holds the controller state encoding and the bus word size so the
// engine and anything that inspects it agree on both.

package mem_dma_pkg;

  // Bytes per bus word; pointers step by this amount after every write.
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-bus memory-to-memory word copy engine
//
// Purpose: copies len 32-bit words from src_addr to dst_addr over one shared
// tri-state memory bus, one read cycle then one write cycle per word, in
// ascending address order. Pointers wrap modulo 2^32.
//
// Build option: MEM_DMA_FILL_EN adds a fill mode (fill, fill_data ports) that
// skips the read phase and writes fill_data to every destination word.
//
// Ports:
//   clk        in     single clock, rising edge
//   rst        in     synchronous active-high reset
//   start      in     one-cycle copy request, only honoured in IDLE
//   src_addr   in 32  first source byte address (latched on start)
//   dst_addr   in 32  first destination byte address (latched on start)
//   len        in     word count (latched on start), 0 gives an immediate done
//   busy       out    high from the cycle after start through DONE
//   done       out    one-cycle completion pulse
//   mem_we     out    bus write strobe
//   mem_addr   out 32 bus byte address, 0 when idle
//   mem_data   inout 32 shared data bus, driven only while mem_we=1
//   fill       in     (MEM_DMA_FILL_EN) select fill mode, latched on start
//   fill_data  in 32  (MEM_DMA_FILL_EN) pattern written in fill mode

module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef MEM_DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  inout  wire  [31:0]      mem_data
);

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr;
  logic [LEN_W-1:0] remain;
  logic [31:0]      data_reg;
  logic [31:0]      wdata;
  logic             fill_q;     // latched mode for the copy in flight
  logic             fill_req;   // mode requested alongside start

`ifdef MEM_DMA_FILL_EN
  logic [31:0] fill_data_q;

  assign fill_req = fill;
  assign wdata    = fill_q ? fill_data_q : data_reg;
`else
  assign fill_req = 1'b0;
  assign fill_q   = 1'b0;
  assign wdata    = data_reg;
`endif

  // The only driver this block places on the shared bus.
  assign mem_data = mem_we ? wdata : 32'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)   state_nxt = DONE;
          else if (fill_req) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_addr  = src_ptr;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_ptr;
        if (remain == LEN_W'(1)) state_nxt = DONE;
        else if (fill_q)         state_nxt = WRITE;
        else                     state_nxt = READ;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: inputs are latched only on a start seen in IDLE, so requests
  // arriving mid-copy never disturb the pointers or count.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr  <= 32'h0;
      dst_ptr  <= 32'h0;
      remain   <= '0;
      data_reg <= 32'h0;
`ifdef MEM_DMA_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            remain  <= len;
`ifdef MEM_DMA_FILL_EN
            fill_q      <= fill;
            fill_data_q <= fill_data;
`endif
          end
        end
        READ: data_reg <= mem_data;
        WRITE: begin
          src_ptr <= src_ptr + 32'(WORD_BYTES);
          dst_ptr <= dst_ptr + 32'(WORD_BYTES);
          remain  <= remain - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - scoreboard bench for mem_dma with a 1024-word ram responder

module tb_mem_dma;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done, mem_we;
  logic [31:0]      mem_addr;
  wire  [31:0]      mem_data;
`ifdef MEM_DMA_FILL_EN
  logic             fill;
  logic [31:0]      fill_data;
`endif

  logic [31:0] ram   [1024];
  logic [31:0] model [1024];
  logic        preload;
  logic [63:0] sb [$];
  logic [63:0] sb_e;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_dma #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
`ifdef MEM_DMA_FILL_EN
    .fill     (fill),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i < 4) return 32'((i + 1) * 17);
    return 32'hA500_0000 ^ 32'(i * 259);
  endfunction

  // Ram responder: drives read data whenever the engine is busy and not
  // writing; captures bus writes unless the bus is in reset.
  assign mem_data = (!mem_we && busy) ? ram[mem_addr[11:2]] : 32'bz;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_we && !rst) begin
      ram[mem_addr[11:2]] <= mem_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (mem_we) begin
      check("wr_data_known", 64'($isunknown(mem_data)), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        sb_e = sb.pop_front();
        check("wr_addr_data", {mem_addr, mem_data}, sb_e);
      end
    end else if (!busy) begin
      check("bus_idle_z", 64'($countones(mem_data)), 64'd0);
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit ign, input bit fl);
    logic [31:0] sp, dp, w;
    int done_at, rd, limit;
    bit busy_ok;
    sp = s; dp = d;
    for (int i = 0; i < n; i++) begin
      w = fl ? 32'hDEAD_BEEF : model[sp[11:2]];
      model[dp[11:2]] = w;
      sb.push_back({dp, w});
      sp += 32'd4; dp += 32'd4;
    end
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
`ifdef MEM_DMA_FILL_EN
    fill = fl; fill_data = 32'hDEAD_BEEF;
`endif
    @(posedge clk);
    done_at = -1; rd = 0; busy_ok = 1'b1; limit = 2 * n + 6;
    for (int k = 1; k <= limit && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (ign && k == 2) begin
        start = 1'b1; src_addr = 32'h40; dst_addr = 32'h380; len = LEN_W'(1);
      end
      if (ign && k == 3) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (busy && !mem_we && !done) rd++;
      if (done) done_at = k;
    end
    check("done_cycle", 64'(done_at), 64'(fl ? n + 1 : 2 * n + 1));
    check("busy_window", 64'(busy_ok), 64'd1);
    check("read_cycles", 64'(rd), 64'(fl ? 0 : n));
    @(negedge clk);
    check("idle_after_busy", {63'd0, busy}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int bad;
    bit saw_done;
    rst = 1'b1; preload = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    for (int i = 0; i < 1024; i++) model[i] = init_word(i);
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_we", {63'd0, mem_we}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);

    // start coincident with reset is dropped
    start = 1'b1; src_addr = 32'h0; dst_addr = 32'h100; len = LEN_W'(4);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; preload = 1'b0;
    check("start_in_rst", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("start_in_rst_we", {63'd0, mem_we}, 64'd0);

    // basic 4-word copy
    run_copy(32'h0, 32'h100, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check("copy4_ram", {32'd0, ram[64 + i]}, 64'((i + 1) * 17));

    // zero-length request
    run_copy(32'h10, 32'h180, 0, 1'b0, 1'b0);

    // reset during the second word's write cycle
    w = model[8]; model[128] = w; sb.push_back({32'h200, w});
    sb.push_back({32'h204, model[9]});
    @(negedge clk);
    start = 1'b1; src_addr = 32'h20; dst_addr = 32'h200; len = LEN_W'(4);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("abort_in_write", {63'd0, mem_we}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_we", {63'd0, mem_we}, 64'd0);
    check("abort_addr", {32'd0, mem_addr}, 64'd0);
    saw_done = done;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    check("abort_sb", 64'(sb.size()), 64'd0);

    // start pulsed mid-copy is ignored
    run_copy(32'h8, 32'h300, 3, 1'b1, 1'b0);

    // pointer wrap with low address bits carried through
    run_copy(32'hFFFF_FFF8, 32'h0000_0801, 3, 1'b0, 1'b0);

    // overlapping ranges copy upward
    run_copy(32'h100, 32'h104, 3, 1'b0, 1'b0);
    check("overlap_top", {32'd0, ram[67]}, {32'd0, 32'h11});

`ifdef MEM_DMA_FILL_EN
    run_copy(32'h0, 32'h40, 3, 1'b0, 1'b1);
    for (int i = 16; i < 19; i++) check("fill_ram", {32'd0, ram[i]}, 64'h0000_0000_DEAD_BEEF);
`endif

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== model[i]) bad++;
    check("ram_vs_model", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 11, width of the word-count input (max 1024 words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 SHALL have port src_addr  input  32  byte address of first source word; latched on accepted start.
REQ-006 SHALL have port dst_addr  input  32  byte address of first destination word; latched on accepted start.
REQ-007 SHALL have port len  input  LEN_W  number of 32-bit words to copy; latched on accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the copy completes.
REQ-010 SHALL have port mem_we  output  1  bus write strobe to memory responders.
REQ-011 SHALL have port mem_addr  output  32  bus byte address.
REQ-012 SHALL have port mem_data  inout  32  shared data bus; driven only while mem_we=1, else high-Z.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-014 IDLE: start=1 and len!=0 -> READ; start=1 and len=0 -> DONE; otherwise stay.
REQ-015 READ: mem_we=0, mem_addr=current src pointer, mem_data=Z; data captured from mem_data into an internal register at the closing edge; -> WRITE.
REQ-016 WRITE: mem_we=1, mem_addr=current dst pointer, mem_data=captured word; at the closing edge src and dst pointers += 4, remaining count -= 1; -> DONE if remaining was 1, else READ.
REQ-017 DONE: done=1 for exactly this one cycle, busy=1; -> IDLE.
REQ-018 SHALL take exactly 2 cycles per word; total start-to-done-pulse latency = 2*len+1 cycles (1 for len=0).
REQ-019 IDLE: mem_we=0, mem_addr=0, mem_data=Z, busy=0, done=0.
REQ-020 start while not in IDLE SHALL be ignored; inputs SHALL not be re-latched mid-copy.
REQ-021 Pointers SHALL increment modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000); low two address bits pass through unchanged.
REQ-022 Overlapping src/dst ranges SHALL be copied in ascending address order with no hazard protection.
REQ-023 mem_data SHALL never be driven in READ, IDLE or DONE (no bus contention with responders).

Reset
REQ-024 rst=1 at any posedge SHALL force IDLE, clear pointers, count and capture register, regardless of state.
REQ-025 During and after reset: mem_we=0, mem_addr=0, mem_data=Z, busy=0, done=0; an aborted copy SHALL produce no done pulse.
REQ-026 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-027 Macro MEM_DMA_FILL_EN SHALL gate a fill mode.
REQ-028 With MEM_DMA_FILL_EN defined: extra ports fill (input, 1) and fill_data (input, 32), latched on accepted start; fill=1 skips READ (IDLE -> WRITE, WRITE -> WRITE), writing fill_data to len words at 1 cycle per word; latency len+1.
REQ-029 Without MEM_DMA_FILL_EN: fill and fill_data ports absent; behaviour exactly as REQ-013..REQ-023.

Structure
REQ-030 Package mem_dma_pkg SHALL hold the state enum and constant WORD_BYTES=4.
REQ-031 Single flat module; no sub-module required; tri-state driver is one continuous assignment inside mem_dma.

Verification (bench attaches the existing 1024-word ram responder to the bus)
REQ-032 Preload ram[0..3]=0x11,0x22,0x33,0x44; start src=0x0 dst=0x100 len=4 -> ram[64..67] match, done at cycle 9 after start, busy high cycles 1-9.
REQ-033 start with len=0 -> done pulse next cycle, mem_we never asserted, memory unchanged.
REQ-034 Assert rst during WRITE of word 2 of len=4 -> next cycle IDLE, mem_we=0, busy=0, no done; only word 1 copied.
REQ-035 Pulse start again while busy with different src -> ignored, original copy completes unchanged.
REQ-036 Bus monitor over all tests: mem_data Z whenever mem_we=0; no X on mem_data during WRITE.
REQ-037 With MEM_DMA_FILL_EN: fill=1 fill_data=0xDEADBEEF dst=0x40 len=3 -> ram[16..18]=0xDEADBEEF, done 4 cycles after start, no READ cycles.
